// File: rtl/hack_pkg.sv
// Shared decode definitions for the Hack CPU: instruction field positions,
// ALU comp encodings, jump codes and the jump-condition helper.
package hack_pkg;

  localparam int OP_BIT   = 15;
  localparam int A_BIT    = 12;
  localparam int COMP_LSB = 6;
  localparam int DEST_LSB = 3;
  localparam int JMP_LSB  = 0;

  localparam logic [5:0] COMP_ZERO = 6'b101010;
  localparam logic [5:0] COMP_ONE  = 6'b111111;
  localparam logic [5:0] COMP_D    = 6'b001100;
  localparam logic [5:0] COMP_A    = 6'b110000;
  localparam logic [5:0] COMP_DP1  = 6'b011111;
  localparam logic [5:0] COMP_DPA  = 6'b000010;

  typedef enum logic [2:0] {
    JNULL = 3'b000,
    JGT   = 3'b001,
    JEQ   = 3'b010,
    JGE   = 3'b011,
    JLT   = 3'b100,
    JNE   = 3'b101,
    JLE   = 3'b110,
    JMP   = 3'b111
  } jump_e;

  typedef struct packed {
    logic       is_c;
    logic       a_sel;
    logic [5:0] comp;
    logic       dest_a;
    logic       dest_d;
    logic       dest_m;
    jump_e      jmp;
  } decode_t;

  // Jump bits select lt/eq/gt; gt means strictly positive (not negative, not zero).
  function automatic logic jump_taken(input jump_e jmp, input logic zr, input logic ng);
    return (jmp[2] & ng) | (jmp[1] & zr) | (jmp[0] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/my_alu.sv
// Fixed-width 16-bit Hack ALU: optional zero/negate of each operand, add or AND,
// optional negate of the result, plus zero and negative flags.
module my_alu (
  output logic [15:0] out,
  output logic        zr,
  output logic        ng,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        zx,
  input  logic        nx,
  input  logic        zy,
  input  logic        ny,
  input  logic        f,
  input  logic        no
);

  logic [15:0] x_z, x_n, y_z, y_n, f_out;

  always_comb begin
    x_z   = zx ? 16'h0000 : x;
    x_n   = nx ? ~x_z : x_z;
    y_z   = zy ? 16'h0000 : y;
    y_n   = ny ? ~y_z : y_z;
    f_out = f ? (x_n + y_n) : (x_n & y_n);
    out   = no ? ~f_out : f_out;
    zr    = (out == 16'h0000);
    ng    = out[15];
  end

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: single-cycle decode of A/C instructions, A/D/PC registers,
// data-memory write strobe and jump resolution around one my_alu instance.
module hack_cpu
  import hack_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] inM,
  output logic [DATA_W-1:0] outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc
);

  decode_t           dec;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zr, alu_ng;
  logic [1:0]        unused_bits;

  assign unused_bits = instruction[14:13];

  always_comb begin
    dec.is_c   = instruction[OP_BIT];
    dec.a_sel  = instruction[A_BIT];
    dec.comp   = instruction[COMP_LSB +: 6];
    dec.dest_a = instruction[DEST_LSB + 2];
    dec.dest_d = instruction[DEST_LSB + 1];
    dec.dest_m = instruction[DEST_LSB];
    dec.jmp    = jump_e'(instruction[JMP_LSB +: 3]);
  end

  assign alu_y = dec.a_sel ? inM : a_q;

  my_alu u_alu (
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng),
    .x   (d_q),
    .y   (alu_y),
    .zx  (dec.comp[5]),
    .nx  (dec.comp[4]),
    .zy  (dec.comp[3]),
    .ny  (dec.comp[2]),
    .f   (dec.comp[1]),
    .no  (dec.comp[0])
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q;
    if (instr_valid) begin
      pc_d = pc_q + ADDR_W'(1);
      if (!dec.is_c) begin
        a_d = {1'b0, instruction[ADDR_W-1:0]};
      end else begin
        if (dec.dest_a) a_d = alu_out;
        if (dec.dest_d) d_d = alu_out;
        // Jump target is the A value before this edge, even when A is also a destination.
        if (jump_taken(dec.jmp, alu_zr, alu_ng)) pc_d = a_q[ADDR_W-1:0];
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      d_q  <= '0;
      pc_q <= '0;
    end else begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  assign outM     = alu_out;
  assign writeM   = rst_n & instr_valid & dec.is_c & dec.dest_m;
  assign addressM = a_q[ADDR_W-1:0];
  assign pc       = pc_q;

endmodule

// File: tb/tb_hack_cpu.sv
// Directed bench for hack_cpu: an instruction-level model (mnemonic ALU table,
// signed jump tests, small RAM) checked every cycle, plus hand-computed literals.
module tb_hack_cpu;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] ram [0:32767];
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  logic [15:0] m_y;
  logic [16:0] m_res;
  logic        m_jmp;

  hack_cpu dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .inM         (inM),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign inM = ram[addressM];

  // Bit 16 flags whether the comp code is one of the documented Hack mnemonics.
  function automatic logic [16:0] alu_model(input logic [5:0] comp, input logic [15:0] x,
                                            input logic [15:0] y);
    logic [15:0] r;
    logic        known;
    known = 1'b1;
    case (comp)
      6'b101010: r = 16'd0;
      6'b111111: r = 16'd1;
      6'b111010: r = 16'hFFFF;
      6'b001100: r = x;
      6'b110000: r = y;
      6'b001101: r = ~x;
      6'b110001: r = ~y;
      6'b001111: r = -x;
      6'b110011: r = -y;
      6'b011111: r = x + 16'd1;
      6'b110111: r = y + 16'd1;
      6'b001110: r = x - 16'd1;
      6'b110010: r = y - 16'd1;
      6'b000010: r = x + y;
      6'b010011: r = x - y;
      6'b000111: r = y - x;
      6'b000000: r = x & y;
      6'b010101: r = x | y;
      default: begin r = 16'd0; known = 1'b0; end
    endcase
    return {known, r};
  endfunction

  function automatic logic jump_model(input logic [2:0] j, input logic [15:0] v);
    int s;
    s = int'($signed(v));
    case (j)
      3'b001:  return s > 0;
      3'b010:  return s == 0;
      3'b011:  return s >= 0;
      3'b100:  return s < 0;
      3'b101:  return s != 0;
      3'b110:  return s <= 0;
      3'b111:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign m_y   = instruction[12] ? ram[m_a[14:0]] : m_a;
  assign m_res = alu_model(instruction[11:6], m_d, m_y);
  assign m_jmp = jump_model(instruction[2:0], m_res[15:0]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a  <= 16'd0;
      m_d  <= 16'd0;
      m_pc <= 15'd0;
    end else if (instr_valid) begin
      if (!instruction[15]) begin
        m_a  <= {1'b0, instruction[14:0]};
        m_pc <= m_pc + 15'd1;
      end else begin
        if (instruction[5]) m_a <= m_res[15:0];
        if (instruction[4]) m_d <= m_res[15:0];
        if (instruction[3]) ram[m_a[14:0]] <= m_res[15:0];
        m_pc <= m_jmp ? m_a[14:0] : m_pc + 15'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("model rst pc", 32'(pc), 32'd0);
      check("model rst writeM", 32'(writeM), 32'd0);
    end else begin
      check("model pc", 32'(pc), 32'(m_pc));
      check("model addressM", 32'(addressM), 32'(m_a[14:0]));
      check("model writeM", 32'(writeM),
            32'(instr_valid & instruction[15] & instruction[3]));
      if (instruction[15] && m_res[16])
        check("model outM", 32'(outM), 32'(m_res[15:0]));
    end
  end

  task automatic drive(input logic v, input logic [15:0] ins);
    instr_valid = v;
    instruction = ins;
  endtask

  task automatic exec(input logic [15:0] ins);
    drive(1'b1, ins);
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [15:0] ins, input logic [15:0] exp, input string name);
    drive(1'b0, ins);
    #1;
    check(name, 32'(outM), 32'(exp));
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 16'(i * 7);
    rst_n = 1'b0;
    drive(1'b1, 16'hE7C8);
    #12;
    check("reset pc", 32'(pc), 32'd0);
    check("reset addressM", 32'(addressM), 32'd0);
    check("reset writeM", 32'(writeM), 32'd0);
    peek(16'hE300, 16'd0, "reset D");
    #10;
    rst_n = 1'b1;

    // @21 then D=A
    exec(16'h0015);
    check("@21 addressM", 32'(addressM), 32'd21);
    check("@21 pc", 32'(pc), 32'd1);
    exec(16'hEC10);
    peek(16'hE300, 16'd21, "D=A D");
    check("D=A pc", 32'(pc), 32'd2);

    // M=D+1 with A = D = 21, then read RAM[21] back via comp M
    drive(1'b1, 16'hE7C8);
    #1;
    check("M=D+1 outM", 32'(outM), 32'd22);
    check("M=D+1 writeM", 32'(writeM), 32'd1);
    check("M=D+1 addressM", 32'(addressM), 32'd21);
    @(posedge clk);
    #1;
    check("M=D+1 pc", 32'(pc), 32'd3);
    peek(16'hFC00, 16'd22, "RAM[21]");

    // D;JGT taken with D = 21, not taken with D = -5
    exec(16'h0064);
    exec(16'hE301);
    check("JGT taken pc", 32'(pc), 32'd100);
    exec(16'h0005);
    exec(16'hEC10);
    exec(16'hE3D0);
    peek(16'hE300, 16'hFFFB, "D=-D D");
    exec(16'h0064);
    exec(16'hE301);
    check("JGT not taken pc", 32'(pc), 32'd105);

    // jump to top of address space, then wrap
    exec(16'h7FFF);
    exec(16'hEA87);
    check("JMP 7FFF pc", 32'(pc), 32'h7FFF);
    exec(16'h0000);
    check("pc wrap", 32'(pc), 32'd0);

    // A=D+1;JMP jumps to old A; new A has bit 15 set
    exec(16'h0032);
    exec(16'hE7E7);
    check("dest A jump pc", 32'(pc), 32'd50);
    check("dest A addressM", 32'(addressM), 32'h7FFC);

    // stall three cycles, then reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'hE7C8);
      #1;
      check("stall writeM", 32'(writeM), 32'd0);
      check("stall pc", 32'(pc), 32'd50);
      check("stall addressM", 32'(addressM), 32'h7FFC);
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst pc", 32'(pc), 32'd0);
    check("async rst addressM", 32'(addressM), 32'd0);
    check("async rst writeM", 32'(writeM), 32'd0);
    check("async rst D", 32'(outM), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    exec(16'h0007);
    check("restart pc", 32'(pc), 32'd1);
    check("restart addressM", 32'(addressM), 32'd7);

    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
